ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage for the CPU. It sits directly downstream of the ALU and captures its result, zero flag and overflow flag together with the instruction's control fields. It converts signed-arithmetic overflow into an Ov exception, resolves conditional branches from the zero flag, and hands the packet to the memory stage through a valid/ready handshake. A 2-entry skid buffer decouples a registered `ex_ready` from `mem_ready`.

## Interface
- No parameters; data width fixed at 32, register index width at 5.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: drop all held and incoming packets; squash pending redirect/exception pulses.
- `ex_valid` in 1: EX presents a packet.
- `ex_ready` out 1: stage can accept; registered.
- `ex_pc` in 32: instruction PC.
- `ex_op` in 4: ALU opcode driven to the ALU.
- `alu_rd` in 32: ALU result.
- `alu_zf` in 1: ALU zero flag.
- `alu_of` in 1: ALU overflow flag.
- `ex_store` in 32: store data (rt value).
- `ex_wreg` in 5: destination register.
- `ex_wen` in 1: register write enable.
- `ex_mem_rd` in 1: load.
- `ex_mem_wr` in 1: store.
- `ex_br` in 2: branch type; 00 none, 01 BEQ, 10 BNE, 11 reserved (treated as none).
- `ex_br_target` in 32: branch target.
- `mem_valid` out 1: packet available to MEM.
- `mem_ready` in 1: MEM accepts.
- `mem_pc`, `mem_result`, `mem_store` out 32 each.
- `mem_wreg` out 5.
- `mem_wen`, `mem_rd`, `mem_wr`, `mem_exc` out 1 each.
- `redirect` out 1: one-cycle pulse, branch taken.
- `redirect_pc` out 32: branch target.
- `exc_valid` out 1: one-cycle pulse, exception raised.
- `exc_code` out 5: exception code.
- `exc_epc` out 32: exception PC.

## Operation
- **Accept:** an EX packet is accepted when `ex_valid && ex_ready && !flush`.
- **Overflow:** `ovf = alu_of && (ex_op == 4'b1011 || ex_op == 4'b1100)`. `alu_of` is ignored for all other opcodes.
- **Overflow packet:** if `ovf`, the accepted packet is stored with `wen`, `mem_rd`, `mem_wr` forced to 0 and `mem_exc = 1`. `exc_valid` pulses with `exc_code = 5'd12` and `exc_epc = ex_pc`.
- **Branch:** `taken = (ex_br == 01 && alu_zf) || (ex_br == 10 && !alu_zf)`, and only when `!ovf`. If taken, `redirect` pulses with `redirect_pc = ex_br_target`. Branch packets still flow to MEM with their `wen` unchanged, so link writes are preserved.
- **Buffer:** two slots, `main` (drives the `mem_*` outputs) and `skid`.
  - Accepted packet goes to `main` if `main` is empty or is leaving this cycle (`mem_ready`). Otherwise it goes to `skid`.
  - When `main` leaves and `skid` is full, `skid` moves into `main` that same edge.
  - Order is strictly FIFO.
- **Ready:** `ex_ready` is registered, equal to `!skid_valid_next`. It is 1 when at most one packet will be held.
- **Flush:** on an edge where `flush` is high, both slots are cleared, the incoming packet is dropped, and the `redirect`/`exc_valid` registers are cleared for the next cycle.
- **Simultaneous events:** flush with accept means flush wins. `mem_ready` with accept while `main` is full and `skid` is empty means `main` is replaced by the new packet and `skid` stays empty.
- **Reset:** all valid bits, `redirect` and `exc_valid` are 0. `ex_ready` is 1. All data outputs (`mem_*`, `redirect_pc`, `exc_code`, `exc_epc`) are 0.

## Timing
- **Latency:** a packet accepted at edge N appears on `mem_valid` and the data outputs in the cycle after edge N.
- **Pulses:** `redirect` and `exc_valid` are registered at the acceptance edge and are high for exactly that one following cycle. They are independent of `mem_ready`.
- **Throughput:** one packet per cycle while `mem_ready` is high.
- **Backpressure:** `ex_ready` falls the cycle after `skid` fills. It rises the cycle after `skid` drains.
- **Payload stability:** `mem_*` outputs hold stable while `mem_valid && !mem_ready`.

## Structure
- **Shared package `cpu_pkg`:**
  - ALU opcode constants, including `ALU_ADD_S = 4'b1011` and `ALU_SUB_S = 4'b1100`.
  - Branch-type encodings.
  - `EXC_OV = 5'd12`.
  - The packed EX/MEM payload struct (pc, result, store, wreg, wen, rd, wr, exc).
- **Sub-module:** `ex_mem_skid`, a generic 2-entry valid/ready skid buffer over the payload struct with flush. The top level holds the overflow/branch logic and the pulse registers.

## Test plan
- **Reset then ADD_S:** reset, then one ADD_S packet with `alu_rd = 0x00000005`, `alu_of = 0`, `mem_ready = 1` → `mem_valid` next cycle with `mem_result = 5`, `mem_wen = 1`; no pulses.
- **Overflow:** ADD_S with `alu_of = 1`, `ex_pc = 0x00400010`, `ex_wen = 1` → `exc_valid` for 1 cycle with code 12 and EPC `0x00400010`; packet arrives with `mem_exc = 1`, `mem_wen = 0`. Same flags on unsigned ADD (`4'b0011`) → no exception.
- **Branches:** BEQ with `alu_zf = 1`, target `0x00400100` → `redirect` pulse with `redirect_pc = 0x00400100`. BNE with `alu_zf = 1` → no redirect.
- **Backpressure:** `mem_ready = 0`, stream 3 packets (A, B, C) → A and B held, `ex_ready` low after B, C is not accepted. Raise `mem_ready` → A, B, C delivered in order on consecutive cycles.
- **Flush with skid full:** flush while `skid` is full and a BEQ-taken packet is being accepted → `mem_valid = 0` next cycle, no `redirect`, `ex_ready = 1`.
- **Reset mid-operation:** assert `rst` asynchronously mid-stream → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, branch encodings, exception codes
// and the packed EX/MEM pipeline payload.
package cpu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_ADD_S = 4'b1011;
    localparam logic [3:0] ALU_SUB_S = 4'b1100;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_RSV  = 2'b11
    } br_t;

    localparam logic [4:0] EXC_OV = 5'd12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  wreg;
        logic        wen;
        logic        rd;
        logic        wr;
        logic        exc;
    } ex_mem_pkt_t;

    // Only the trapping add/subtract variants may raise an overflow exception.
    function automatic logic is_trap_op(input logic [3:0] op);
        return (op == ALU_ADD_S) || (op == ALU_SUB_S);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Signal bundle between EX, the EX/MEM stage and MEM. The stage connects
// through the slave modport; the surrounding pipeline uses master.
interface ex_mem_stage_if;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [3:0]  ex_op;
    logic [31:0] alu_rd;
    logic        alu_zf;
    logic        alu_of;
    logic [31:0] ex_store;
    logic [4:0]  ex_wreg;
    logic        ex_wen;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [1:0]  ex_br;
    logic [31:0] ex_br_target;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_pc;
    logic [31:0] mem_result;
    logic [31:0] mem_store;
    logic [4:0]  mem_wreg;
    logic        mem_wen;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_exc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;

    modport master (
        output flush, ex_valid, ex_pc, ex_op, alu_rd, alu_zf, alu_of, ex_store,
               ex_wreg, ex_wen, ex_mem_rd, ex_mem_wr, ex_br, ex_br_target, mem_ready,
        input  ex_ready, mem_valid, mem_pc, mem_result, mem_store, mem_wreg, mem_wen,
               mem_rd, mem_wr, mem_exc, redirect, redirect_pc, exc_valid, exc_code, exc_epc
    );

    modport slave (
        input  flush, ex_valid, ex_pc, ex_op, alu_rd, alu_zf, alu_of, ex_store,
               ex_wreg, ex_wen, ex_mem_rd, ex_mem_wr, ex_br, ex_br_target, mem_ready,
        output ex_ready, mem_valid, mem_pc, mem_result, mem_store, mem_wreg, mem_wen,
               mem_rd, mem_wr, mem_exc, redirect, redirect_pc, exc_valid, exc_code, exc_epc
    );
endinterface

// File: rtl/ex_mem_skid.sv
// Two-entry valid/ready skid buffer over the EX/MEM payload. in_ready is
// registered so the upstream ready path never sees out_ready combinationally.
module ex_mem_skid
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  ex_mem_pkt_t in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output ex_mem_pkt_t out_data
);

    logic        main_v, skid_v, rdy;
    ex_mem_pkt_t main_d, skid_d;
    logic        main_v_n, skid_v_n, push;
    ex_mem_pkt_t main_d_n, skid_d_n;

    // The skid slot only fills while main is stalled, and ready is low whenever
    // skid is full, so a push never collides with a full skid slot.
    always_comb begin
        main_v_n = main_v;
        skid_v_n = skid_v;
        main_d_n = main_d;
        skid_d_n = skid_d;
        push     = in_valid && rdy && !flush;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (!main_v || out_ready) begin
            if (skid_v) begin
                main_v_n = 1'b1;
                main_d_n = skid_d;
                skid_v_n = push;
                if (push) skid_d_n = in_data;
            end else begin
                main_v_n = push;
                if (push) main_d_n = in_data;
            end
        end else if (push) begin
            skid_v_n = 1'b1;
            skid_d_n = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
            rdy    <= 1'b1;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            main_d <= main_d_n;
            skid_d <= skid_d_n;
            rdy    <= !skid_v_n;
        end
    end

    assign in_ready  = rdy;
    assign out_valid = main_v;
    assign out_data  = main_d;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: turns trapping-op overflow into an Ov exception,
// resolves conditional branches and buffers packets toward MEM.
module ex_mem_stage
    import cpu_pkg::*;
(
    input logic          clk,
    input logic          rst,
    ex_mem_stage_if.slave bus
);

    logic        ovf, taken, accept, ready;
    ex_mem_pkt_t pkt_in, pkt_out;
    logic        redirect_q, exc_valid_q;
    logic [31:0] redirect_pc_q, exc_epc_q;
    logic [4:0]  exc_code_q;

    assign ovf    = bus.alu_of && is_trap_op(bus.ex_op);
    assign taken  = !ovf && (((bus.ex_br == BR_EQ) && bus.alu_zf) ||
                             ((bus.ex_br == BR_NE) && !bus.alu_zf));
    assign accept = bus.ex_valid && ready && !bus.flush;

    // An overflowing instruction must not write back or touch memory.
    always_comb begin
        pkt_in.pc     = bus.ex_pc;
        pkt_in.result = bus.alu_rd;
        pkt_in.store  = bus.ex_store;
        pkt_in.wreg   = bus.ex_wreg;
        pkt_in.wen    = bus.ex_wen && !ovf;
        pkt_in.rd     = bus.ex_mem_rd && !ovf;
        pkt_in.wr     = bus.ex_mem_wr && !ovf;
        pkt_in.exc    = ovf;
    end

    ex_mem_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.ex_valid),
        .in_ready  (ready),
        .in_data   (pkt_in),
        .out_valid (bus.mem_valid),
        .out_ready (bus.mem_ready),
        .out_data  (pkt_out)
    );

    // Pulses depend only on acceptance, never on MEM backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            exc_valid_q   <= 1'b0;
            exc_code_q    <= '0;
            exc_epc_q     <= '0;
        end else if (bus.flush) begin
            redirect_q  <= 1'b0;
            exc_valid_q <= 1'b0;
        end else begin
            redirect_q  <= accept && taken;
            exc_valid_q <= accept && ovf;
            if (accept && taken) redirect_pc_q <= bus.ex_br_target;
            if (accept && ovf) begin
                exc_code_q <= EXC_OV;
                exc_epc_q  <= bus.ex_pc;
            end
        end
    end

    assign bus.ex_ready    = ready;
    assign bus.mem_pc      = pkt_out.pc;
    assign bus.mem_result  = pkt_out.result;
    assign bus.mem_store   = pkt_out.store;
    assign bus.mem_wreg    = pkt_out.wreg;
    assign bus.mem_wen     = pkt_out.wen;
    assign bus.mem_rd      = pkt_out.rd;
    assign bus.mem_wr      = pkt_out.wr;
    assign bus.mem_exc     = pkt_out.exc;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.exc_valid   = exc_valid_q;
    assign bus.exc_code    = exc_code_q;
    assign bus.exc_epc     = exc_epc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: reset, overflow, branches,
// throughput, backpressure, flush and asynchronous reset.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rd,
                         input logic zf, input logic of, input logic wen, input logic mrd,
                         input logic [1:0] br, input logic [31:0] tgt);
        bus.ex_valid     = 1'b1;
        bus.ex_op        = op;
        bus.ex_pc        = pc;
        bus.alu_rd       = rd;
        bus.alu_zf       = zf;
        bus.alu_of       = of;
        bus.ex_store     = rd ^ 32'hFFFF_0000;
        bus.ex_wreg      = 5'd7;
        bus.ex_wen       = wen;
        bus.ex_mem_rd    = mrd;
        bus.ex_mem_wr    = 1'b0;
        bus.ex_br        = br;
        bus.ex_br_target = tgt;
    endtask

    task automatic idle();
        bus.ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b1;
        drive(ALU_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, 32'h0);
        idle();
        step();
        step();
        compared++; if (bus.mem_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_valid: got %b want 0", bus.mem_valid); end
        compared++; if (bus.ex_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ex_ready: got %b want 1", bus.ex_ready); end
        compared++; if (bus.redirect !== 1'b0 || bus.exc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pulses: got %b%b want 00", bus.redirect, bus.exc_valid); end
        compared++; if (bus.mem_result !== 32'h0 || bus.mem_pc !== 32'h0 || bus.exc_code !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_data: got %h %h %h want 0", bus.mem_result, bus.mem_pc, bus.exc_code); end
        rst = 1'b0;
        step();
        compared++; if (bus.ex_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_ready: got %b want 1", bus.ex_ready); end
    endtask

    task automatic test_add_s();
        bus.mem_ready = 1'b1;
        drive(ALU_ADD_S, 32'h0040_0000, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        idle();
        compared++; if (bus.mem_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL add_valid: got %b want 1", bus.mem_valid); end
        compared++; if (bus.mem_result !== 32'h5) begin mismatched++; $display("[TB] FAIL add_result: got %h want 00000005", bus.mem_result); end
        compared++; if (bus.mem_wen !== 1'b1 || bus.mem_exc !== 1'b0) begin mismatched++; $display("[TB] FAIL add_flags: got wen=%b exc=%b want 1 0", bus.mem_wen, bus.mem_exc); end
        compared++; if (bus.mem_store !== 32'hFFFF_0005 || bus.mem_wreg !== 5'd7) begin mismatched++; $display("[TB] FAIL add_store: got %h %0d want ffff0005 7", bus.mem_store, bus.mem_wreg); end
        compared++; if (bus.redirect !== 1'b0 || bus.exc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL add_pulses: got %b%b want 00", bus.redirect, bus.exc_valid); end
        step();
        compared++; if (bus.mem_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL add_drain: got %b want 0", bus.mem_valid); end
    endtask

    task automatic test_overflow();
        bus.mem_ready = 1'b1;
        drive(ALU_ADD_S, 32'h0040_0010, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, BR_NONE, 32'h0);
        step();
        compared++; if (bus.exc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ov_exc_valid: got %b want 1", bus.exc_valid); end
        compared++; if (bus.exc_code !== 5'd12 || bus.exc_epc !== 32'h0040_0010) begin mismatched++; $display("[TB] FAIL ov_code_epc: got %0d %h want 12 00400010", bus.exc_code, bus.exc_epc); end
        compared++; if (bus.mem_exc !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL ov_packet: got exc=%b wen=%b rd=%b want 1 0 0", bus.mem_exc, bus.mem_wen, bus.mem_rd); end
        drive(ALU_ADD, 32'h0040_0014, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        idle();
        compared++; if (bus.exc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL unsigned_no_exc: got %b want 0", bus.exc_valid); end
        compared++; if (bus.mem_exc !== 1'b0 || bus.mem_wen !== 1'b1 || bus.mem_pc !== 32'h0040_0014) begin mismatched++; $display("[TB] FAIL unsigned_packet: got exc=%b wen=%b pc=%h want 0 1 00400014", bus.mem_exc, bus.mem_wen, bus.mem_pc); end
        compared++; if (bus.exc_epc !== 32'h0040_0010) begin mismatched++; $display("[TB] FAIL epc_hold: got %h want 00400010", bus.exc_epc); end
        step();
    endtask

    task automatic test_branch();
        bus.mem_ready = 1'b1;
        drive(ALU_SUB, 32'h0040_0020, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, BR_EQ, 32'h0040_0100);
        step();
        compared++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0040_0100) begin mismatched++; $display("[TB] FAIL beq_taken: got %b %h want 1 00400100", bus.redirect, bus.redirect_pc); end
        compared++; if (bus.mem_wen !== 1'b1 || bus.mem_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL beq_link: got wen=%b valid=%b want 1 1", bus.mem_wen, bus.mem_valid); end
        drive(ALU_SUB, 32'h0040_0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, BR_NE, 32'h0040_0200);
        step();
        compared++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0040_0100) begin mismatched++; $display("[TB] FAIL bne_not_taken: got %b %h want 0 00400100", bus.redirect, bus.redirect_pc); end
        drive(ALU_SUB_S, 32'h0040_0028, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, BR_EQ, 32'h0040_0300);
        step();
        compared++; if (bus.redirect !== 1'b0 || bus.exc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_blocks_branch: got redir=%b exc=%b want 0 1", bus.redirect, bus.exc_valid); end
        drive(ALU_SUB, 32'h0040_002C, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, BR_RSV, 32'h0040_0500);
        step();
        compared++; if (bus.redirect !== 1'b0) begin mismatched++; $display("[TB] FAIL reserved_br: got %b want 0", bus.redirect); end
        drive(ALU_SUB, 32'h0040_0030, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NE, 32'h0040_0400);
        step();
        idle();
        compared++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0040_0400) begin mismatched++; $display("[TB] FAIL bne_taken: got %b %h want 1 00400400", bus.redirect, bus.redirect_pc); end
        step();
        compared++; if (bus.redirect !== 1'b0) begin mismatched++; $display("[TB] FAIL redirect_one_cycle: got %b want 0", bus.redirect); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h11;
        vals[1] = 32'h22;
        vals[2] = 32'h33;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ALU_ADD, 32'h0040_0040 + 32'(4 * i), vals[i], 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
            step();
            compared++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== vals[i] || bus.ex_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_%0d: got v=%b r=%h rdy=%b want 1 %h 1", i, bus.mem_valid, bus.mem_result, bus.ex_ready, vals[i]); end
        end
        idle();
        step();
        compared++; if (bus.mem_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_drain: got %b want 0", bus.mem_valid); end
    endtask

    task automatic test_backpressure();
        bus.mem_ready = 1'b0;
        drive(ALU_ADD, 32'h0040_0060, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        compared++; if (bus.mem_result !== 32'hA || bus.ex_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_a: got r=%h rdy=%b want a 1", bus.mem_result, bus.ex_ready); end
        drive(ALU_ADD, 32'h0040_0064, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        compared++; if (bus.mem_result !== 32'hA || bus.ex_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_b_held: got r=%h rdy=%b want a 0", bus.mem_result, bus.ex_ready); end
        drive(ALU_ADD, 32'h0040_0068, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        compared++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'hA || bus.ex_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_c_blocked: got v=%b r=%h rdy=%b want 1 a 0", bus.mem_valid, bus.mem_result, bus.ex_ready); end
        bus.mem_ready = 1'b1;
        step();
        compared++; if (bus.mem_result !== 32'hB || bus.ex_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_deliver_b: got r=%h rdy=%b want b 1", bus.mem_result, bus.ex_ready); end
        step();
        idle();
        compared++; if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'hC) begin mismatched++; $display("[TB] FAIL bp_deliver_c: got v=%b r=%h want 1 c", bus.mem_valid, bus.mem_result); end
        step();
        compared++; if (bus.mem_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drain: got %b want 0", bus.mem_valid); end
    endtask

    task automatic test_flush();
        bus.mem_ready = 1'b0;
        drive(ALU_ADD, 32'h0040_0080, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        drive(ALU_ADD, 32'h0040_0084, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        drive(ALU_SUB, 32'h0040_0088, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, BR_EQ, 32'h0040_0600);
        bus.flush = 1'b1;
        step();
        compared++; if (bus.mem_valid !== 1'b0 || bus.redirect !== 1'b0 || bus.ex_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_full: got v=%b redir=%b rdy=%b want 0 0 1", bus.mem_valid, bus.redirect, bus.ex_ready); end
        bus.mem_ready = 1'b1;
        step();
        compared++; if (bus.mem_valid !== 1'b0 || bus.redirect !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_accept: got v=%b redir=%b want 0 0", bus.mem_valid, bus.redirect); end
        bus.flush = 1'b0;
        step();
        idle();
        compared++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0040_0600 || bus.mem_pc !== 32'h0040_0088) begin mismatched++; $display("[TB] FAIL post_flush_branch: got %b %h %h want 1 00400600 00400088", bus.redirect, bus.redirect_pc, bus.mem_pc); end
        step();
    endtask

    task automatic test_async_reset();
        bus.mem_ready = 1'b0;
        drive(ALU_ADD, 32'h0040_00A0, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0, BR_NONE, 32'h0);
        step();
        drive(ALU_SUB, 32'h0040_00A4, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, BR_EQ, 32'h0040_0700);
        step();
        idle();
        compared++; if (bus.redirect !== 1'b1 || bus.ex_ready !== 1'b0 || bus.mem_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL pre_reset_state: got redir=%b rdy=%b v=%b want 1 0 1", bus.redirect, bus.ex_ready, bus.mem_valid); end
        #1 rst = 1'b1;
        #1;
        compared++; if (bus.mem_valid !== 1'b0 || bus.redirect !== 1'b0 || bus.exc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL async_valids: got v=%b redir=%b exc=%b want 0 0 0", bus.mem_valid, bus.redirect, bus.exc_valid); end
        compared++; if (bus.ex_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL async_ready: got %b want 1", bus.ex_ready); end
        compared++; if (bus.mem_result !== 32'h0 || bus.redirect_pc !== 32'h0 || bus.exc_code !== 5'd0 || bus.exc_epc !== 32'h0) begin mismatched++; $display("[TB] FAIL async_data: got %h %h %h %h want 0", bus.mem_result, bus.redirect_pc, bus.exc_code, bus.exc_epc); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_add_s();
        test_overflow();
        test_branch();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
